// File: rtl/program_counter.sv
// Fetch program counter and fetch-to-decode instruction register for the RV32 core.
// Build option: define PC_ALIGN_EN to force redirect targets to word alignment.
module program_counter #(
  parameter int unsigned             ADDR_W     = 32,
  parameter int unsigned             INST_W     = 32,
  parameter logic [ADDR_W-1:0]       RESET_ADDR = ADDR_W'(32'h0000_0000),
  parameter logic [INST_W-1:0]       NOP_INST   = INST_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              hold,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o
);

  localparam int unsigned INST_BYTES = 4;

  logic [ADDR_W-1:0] jump_target_c;
  logic [ADDR_W-1:0] pc_next_c;
  logic [INST_W-1:0] inst_next_c;

`ifdef PC_ALIGN_EN
  assign jump_target_c = {jump_addr[ADDR_W-1:2], 2'b00};
`else
  assign jump_target_c = jump_addr;
`endif

  // Redirect flushes the wrong-path word; stall holds both registers.
  always_comb begin
    pc_next_c   = pc_o + ADDR_W'(INST_BYTES);
    inst_next_c = inst;
    if (jump) begin
      pc_next_c   = jump_target_c;
      inst_next_c = NOP_INST;
    end else if (hold) begin
      pc_next_c   = pc_o;
      inst_next_c = inst_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o   <= RESET_ADDR;
      inst_o <= NOP_INST;
    end else begin
      pc_o   <= pc_next_c;
      inst_o <= inst_next_c;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (honours PC_ALIGN_EN when defined).
module tb_program_counter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP  = 32'h0000_0013;
  localparam logic [INST_W-1:0] WORD = 32'h5550_4793;

  logic              clk;
  logic              rst;
  logic [INST_W-1:0] inst;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              hold;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] inst_o;

  int checks;
  int errors;

  program_counter #(
    .ADDR_W    (ADDR_W),
    .INST_W    (INST_W),
    .RESET_ADDR(32'h0000_0000),
    .NOP_INST  (NOP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inst     (inst),
    .jump     (jump),
    .jump_addr(jump_addr),
    .hold     (hold),
    .pc_o     (pc_o),
    .inst_o   (inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle before sampling and before the next drive.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; jump = 1'b0; hold = 1'b0; jump_addr = '0;
    step();
    checks++;
    if (pc_o !== 32'h0) begin
      errors++; $display("FAIL reset_pc got %h want %h", pc_o, 32'h0);
    end
    checks++;
    if (inst_o !== NOP) begin
      errors++; $display("FAIL reset_inst got %h want %h", inst_o, NOP);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [ADDR_W-1:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc_o !== exp_pc[i]) begin
        errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc_o, exp_pc[i]);
      end
      checks++;
      if (inst_o !== WORD) begin
        errors++; $display("FAIL seq_inst[%0d] got %h want %h", i, inst_o, WORD);
      end
    end
  endtask

  task automatic test_hold();
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    checks++;
    if (pc_o !== 32'h8) begin
      errors++; $display("FAIL hold_setup_pc got %h want %h", pc_o, 32'h8);
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc_o !== 32'h8) begin
        errors++; $display("FAIL hold_pc[%0d] got %h want %h", i, pc_o, 32'h8);
      end
      checks++;
      if (inst_o !== WORD) begin
        errors++; $display("FAIL hold_inst[%0d] got %h want %h", i, inst_o, WORD);
      end
    end
    hold = 1'b0;
    step();
    checks++;
    if (pc_o !== 32'hC) begin
      errors++; $display("FAIL hold_resume_pc got %h want %h", pc_o, 32'hC);
    end
  endtask

  task automatic test_jump_over_hold();
    logic [ADDR_W-1:0] exp_unaligned;
`ifdef PC_ALIGN_EN
    exp_unaligned = 32'h0001_4294;
`else
    exp_unaligned = 32'h0001_4297;
`endif
    hold = 1'b1; jump = 1'b1; jump_addr = 32'h0;
    step();
    checks++;
    if (pc_o !== 32'h0) begin
      errors++; $display("FAIL jump_hold_pc got %h want %h", pc_o, 32'h0);
    end
    checks++;
    if (inst_o !== NOP) begin
      errors++; $display("FAIL jump_hold_inst got %h want %h", inst_o, NOP);
    end
    jump_addr = 32'h0001_4294;
    step();
    checks++;
    if (pc_o !== 32'h0001_4294) begin
      errors++; $display("FAIL jump_target_pc got %h want %h", pc_o, 32'h0001_4294);
    end
    jump_addr = 32'h0001_4297;
    step();
    checks++;
    if (pc_o !== exp_unaligned) begin
      errors++; $display("FAIL jump_unaligned_pc got %h want %h", pc_o, exp_unaligned);
    end
    // Stall after a flush keeps the bubble in place.
    jump = 1'b0;
    step();
    checks++;
    if (pc_o !== exp_unaligned || inst_o !== NOP) begin
      errors++; $display("FAIL post_jump_hold got %h/%h want %h/%h",
                         pc_o, inst_o, exp_unaligned, NOP);
    end
    // Increment keeps the low bits of the loaded target.
    hold = 1'b0;
    step();
    checks++;
    if (pc_o !== exp_unaligned + 32'h4) begin
      errors++; $display("FAIL unaligned_incr_pc got %h want %h", pc_o, exp_unaligned + 32'h4);
    end
    checks++;
    if (inst_o !== WORD) begin
      errors++; $display("FAIL unaligned_incr_inst got %h want %h", inst_o, WORD);
    end
  endtask

  task automatic test_jump_self();
    logic [ADDR_W-1:0] here;
    jump_addr = 32'h0000_0100; jump = 1'b1;
    step();
    jump = 1'b0;
    step();
    here = 32'h0000_0104;
    jump_addr = here; jump = 1'b1;
    step();
    checks++;
    if (pc_o !== here || inst_o !== NOP) begin
      errors++; $display("FAIL jump_self got %h/%h want %h/%h", pc_o, inst_o, here, NOP);
    end
    jump = 1'b0;
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
    step();
    checks++;
    if (pc_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_setup_pc got %h want %h", pc_o, 32'hFFFF_FFFC);
    end
    jump = 1'b0;
    step();
    checks++;
    if (pc_o !== 32'h0) begin
      errors++; $display("FAIL wrap_pc got %h want %h", pc_o, 32'h0);
    end
    checks++;
    if (inst_o !== WORD) begin
      errors++; $display("FAIL wrap_inst got %h want %h", inst_o, WORD);
    end
  endtask

  task automatic test_reset_priority();
    step(); step();
    checks++;
    if (pc_o !== 32'h8) begin
      errors++; $display("FAIL prio_setup_pc got %h want %h", pc_o, 32'h8);
    end
    rst = 1'b1; jump = 1'b1; hold = 1'b1; jump_addr = 32'h0000_0200;
    step();
    checks++;
    if (pc_o !== 32'h0) begin
      errors++; $display("FAIL prio_pc got %h want %h", pc_o, 32'h0);
    end
    checks++;
    if (inst_o !== NOP) begin
      errors++; $display("FAIL prio_inst got %h want %h", inst_o, NOP);
    end
    rst = 1'b0; jump = 1'b0; hold = 1'b0;
    step();
    checks++;
    if (pc_o !== 32'h4) begin
      errors++; $display("FAIL prio_resume_pc got %h want %h", pc_o, 32'h4);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    inst = WORD;
    rst = 1'b1; jump = 1'b0; hold = 1'b0; jump_addr = '0;
    #1;
    test_reset();
    test_sequential();
    test_hold();
    test_jump_over_hold();
    test_jump_self();
    test_wrap();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
